// File: rtl/paddle_powerup_ctrl.sv
// Paddle-size power-up sequencer: turns drop captures into PowOn / size controls
// with a lifetime timer, same-type refresh, opposite-type gap, pause freeze and level clear.
module paddle_powerup_ctrl #(
    parameter int unsigned POW_FRAMES  = 600,
    parameter int unsigned GAP_FRAMES  = 2,
    parameter int unsigned WARN_FRAMES = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       levelChange,
    input  logic       noMore,
    input  logic       capture_valid,
    input  logic [1:0] capture_type,
    output logic       PowOn,
    output logic       PaddleSizeUpPow,
    output logic       PaddleSizeDownPow,
    output logic       pow_warn,
    output logic       pow_expired,
    output logic [9:0] frames_left
);

    localparam int unsigned CW = 10;
    localparam logic [1:0] T_NONE   = 2'b00;
    localparam logic [1:0] T_GROW   = 2'b01;
    localparam logic [1:0] T_SHRINK = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        SWITCH = 2'b10
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] timer, timer_n;
    logic [CW-1:0] gap, gap_n;
    logic [1:0]    ptype, ptype_n;
    logic [1:0]    pend, pend_n;
    logic          expired_n;
    logic          cap_ok;

    assign cap_ok = capture_valid && (capture_type == T_GROW || capture_type == T_SHRINK);

    // State and registered outputs; outputs are decoded from the next-state values
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state             <= IDLE;
            timer             <= '0;
            gap               <= '0;
            ptype             <= T_NONE;
            pend              <= T_NONE;
            PowOn             <= 1'b0;
            PaddleSizeUpPow   <= 1'b0;
            PaddleSizeDownPow <= 1'b0;
            pow_warn          <= 1'b0;
            pow_expired       <= 1'b0;
            frames_left       <= '0;
        end else begin
            state             <= state_n;
            timer             <= timer_n;
            gap               <= gap_n;
            ptype             <= ptype_n;
            pend              <= pend_n;
            PowOn             <= (state_n == ACTIVE);
            PaddleSizeUpPow   <= (state_n == ACTIVE) && (ptype_n == T_GROW);
            PaddleSizeDownPow <= (state_n == ACTIVE) && (ptype_n == T_SHRINK);
            pow_warn          <= (state_n == ACTIVE) && (timer_n <= CW'(WARN_FRAMES));
            pow_expired       <= expired_n;
            frames_left       <= (state_n == ACTIVE) ? timer_n : '0;
        end
    end

    // Next-state: levelChange beats capture, capture beats timer/gap advance
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        gap_n     = gap;
        ptype_n   = ptype;
        pend_n    = pend;
        expired_n = 1'b0;
        if (levelChange) begin
            state_n = IDLE;
            timer_n = '0;
            gap_n   = '0;
            ptype_n = T_NONE;
            pend_n  = T_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (cap_ok) begin
                        state_n = ACTIVE;
                        ptype_n = capture_type;
                        timer_n = CW'(POW_FRAMES);
                    end
                end
                ACTIVE: begin
                    if (cap_ok && capture_type == ptype) begin
                        timer_n = CW'(POW_FRAMES);
                    end else if (cap_ok) begin
                        state_n = SWITCH;
                        pend_n  = capture_type;
                        gap_n   = CW'(GAP_FRAMES);
                        timer_n = '0;
                        ptype_n = T_NONE;
                    end else if (!noMore) begin
                        if (timer == CW'(1)) begin
                            state_n   = IDLE;
                            timer_n   = '0;
                            ptype_n   = T_NONE;
                            expired_n = 1'b1;
                        end else begin
                            timer_n = timer - CW'(1);
                        end
                    end
                end
                SWITCH: begin
                    // Last capture during the gap wins, including one on the final gap frame
                    if (cap_ok) begin
                        pend_n = capture_type;
                    end
                    if (!noMore) begin
                        if (gap == CW'(1)) begin
                            state_n = ACTIVE;
                            ptype_n = pend_n;
                            timer_n = CW'(POW_FRAMES);
                            pend_n  = T_NONE;
                            gap_n   = '0;
                        end else begin
                            gap_n = gap - CW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                    gap_n   = '0;
                    ptype_n = T_NONE;
                    pend_n  = T_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_powerup_ctrl.sv
// Bench for paddle_powerup_ctrl: directed scenarios with literal expectations, then random
// stimulus, all checked every frame against a behavioural model.
module tb_paddle_powerup_ctrl;

    localparam int POW  = 600;
    localparam int GAP  = 2;
    localparam int WARN = 120;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       levelChange = 1'b0;
    logic       noMore = 1'b0;
    logic       capture_valid = 1'b0;
    logic [1:0] capture_type = 2'b00;
    logic       PowOn, PaddleSizeUpPow, PaddleSizeDownPow, pow_warn, pow_expired;
    logic [9:0] frames_left;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model: mode 0 = off, 1 = power-up running, 2 = normal-size gap before a new type
    int m_mode = 0;
    int m_left = 0;
    int m_gap  = 0;
    int m_kind = 0;
    int m_next = 0;
    bit m_exp  = 1'b0;

    paddle_powerup_ctrl #(.POW_FRAMES(POW), .GAP_FRAMES(GAP), .WARN_FRAMES(WARN)) dut (
        .frame_clk        (frame_clk),
        .Reset            (Reset),
        .levelChange      (levelChange),
        .noMore           (noMore),
        .capture_valid    (capture_valid),
        .capture_type     (capture_type),
        .PowOn            (PowOn),
        .PaddleSizeUpPow  (PaddleSizeUpPow),
        .PaddleSizeDownPow(PaddleSizeDownPow),
        .pow_warn         (pow_warn),
        .pow_expired      (pow_expired),
        .frames_left      (frames_left)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_left = 0; m_gap = 0; m_kind = 0; m_next = 0; m_exp = 1'b0;
    endtask

    always @(posedge Reset) model_clear();

    always @(posedge frame_clk) begin
        bit cap;
        int t;
        if (Reset) begin
            model_clear();
        end else begin
            cap = capture_valid && (capture_type == 2'd1 || capture_type == 2'd2);
            t = int'(capture_type);
            m_exp = 1'b0;
            if (levelChange) begin
                model_clear();
            end else if (m_mode == 0) begin
                if (cap) begin m_mode = 1; m_kind = t; m_left = POW; end
            end else if (m_mode == 1) begin
                if (cap && t == m_kind) m_left = POW;
                else if (cap) begin m_mode = 2; m_next = t; m_gap = GAP; m_left = 0; end
                else if (!noMore) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_mode = 0; m_kind = 0; m_exp = 1'b1; end
                end
            end else begin
                if (cap) m_next = t;
                if (!noMore) begin
                    m_gap = m_gap - 1;
                    if (m_gap == 0) begin m_mode = 1; m_kind = m_next; m_left = POW; m_next = 0; end
                end
            end
        end
    end

    // Every-frame comparison against the model, away from the active edge
    always @(negedge frame_clk) begin
        if (cmp_en) begin
            chk("PowOn", int'(PowOn), int'(m_mode == 1));
            chk("SizeUp", int'(PaddleSizeUpPow), int'(m_mode == 1 && m_kind == 1));
            chk("SizeDown", int'(PaddleSizeDownPow), int'(m_mode == 1 && m_kind == 2));
            chk("warn", int'(pow_warn), int'(m_mode == 1 && m_left <= WARN));
            chk("expired", int'(pow_expired), int'(m_exp));
            chk("frames_left", int'(frames_left), (m_mode == 1) ? m_left : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic capture(input logic [1:0] t);
        capture_valid = 1'b1;
        capture_type = t;
        cyc(1);
        capture_valid = 1'b0;
        capture_type = 2'b00;
    endtask

    initial begin
        #2;
        chk("reset_PowOn", int'(PowOn), 0);
        chk("reset_frames_left", int'(frames_left), 0);
        cmp_en = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(3);

        // Grow capture, lifetime, warn threshold and natural expiry
        capture(2'b01);
        chk("grow_on", int'(PowOn), 1);
        chk("grow_up", int'(PaddleSizeUpPow), 1);
        chk("grow_left", int'(frames_left), 600);
        cyc(479);
        chk("prewarn_left", int'(frames_left), 121);
        chk("prewarn", int'(pow_warn), 0);
        cyc(1);
        chk("warn_left", int'(frames_left), 120);
        chk("warn", int'(pow_warn), 1);
        cyc(119);
        chk("last_on", int'(PowOn), 1);
        chk("last_left", int'(frames_left), 1);
        cyc(1);
        chk("expire_off", int'(PowOn), 0);
        chk("expire_pulse", int'(pow_expired), 1);
        cyc(1);
        chk("expire_once", int'(pow_expired), 0);

        // Same-type refresh
        capture(2'b01);
        cyc(595);
        chk("refresh_pre", int'(frames_left), 5);
        capture(2'b01);
        chk("refresh_left", int'(frames_left), 600);
        chk("refresh_noexp", int'(pow_expired), 0);

        // Opposite-type switch through the normal-size gap
        capture(2'b10);
        chk("gap1_on", int'(PowOn), 0);
        chk("gap1_flags", int'({PaddleSizeUpPow, PaddleSizeDownPow}), 0);
        cyc(1);
        chk("gap2_on", int'(PowOn), 0);
        cyc(1);
        chk("shrink_down", int'(PaddleSizeDownPow), 1);
        chk("shrink_left", int'(frames_left), 600);
        capture(2'b01);
        capture(2'b10);
        chk("gap_over_on", int'(PowOn), 0);
        cyc(1);
        chk("lastwins_down", int'(PaddleSizeDownPow), 1);
        chk("lastwins_up", int'(PaddleSizeUpPow), 0);

        // Pause freeze and ignored capture types
        cyc(300);
        chk("pause_pre", int'(frames_left), 300);
        noMore = 1'b1;
        cyc(50);
        chk("pause_hold", int'(frames_left), 300);
        noMore = 1'b0;
        cyc(1);
        chk("pause_resume", int'(frames_left), 299);
        capture(2'b11);
        chk("ignore11", int'(frames_left), 298);
        capture(2'b00);
        chk("ignore00", int'(frames_left), 297);
        chk("ignore_down", int'(PaddleSizeDownPow), 1);

        // levelChange with a simultaneous capture, from ACTIVE and from SWITCH
        levelChange = 1'b1;
        capture(2'b01);
        levelChange = 1'b0;
        chk("lc_on", int'(PowOn), 0);
        chk("lc_left", int'(frames_left), 0);
        cyc(3);
        chk("lc_stay", int'(PowOn), 0);
        capture(2'b01);
        capture(2'b10);
        levelChange = 1'b1;
        capture(2'b01);
        levelChange = 1'b0;
        cyc(4);
        chk("lc_sw_on", int'(PowOn), 0);

        // Asynchronous reset between edges
        capture(2'b01);
        cyc(5);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_on", int'(PowOn), 0);
        chk("async_left", int'(frames_left), 0);
        Reset = 1'b0;
        cyc(2);
        capture(2'b01);
        chk("post_reset_left", int'(frames_left), 600);
        chk("post_reset_up", int'(PaddleSizeUpPow), 1);

        // Random traffic, checked by the every-frame compare
        for (int i = 0; i < 5000; i++) begin
            capture_valid = ($urandom_range(0, 299) == 0);
            capture_type  = 2'($urandom_range(0, 3));
            noMore        = ($urandom_range(0, 9) == 0);
            levelChange   = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        capture_valid = 1'b0;
        noMore = 1'b0;
        levelChange = 1'b0;
        cyc(2);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_powerup_ctrl.md
Name: paddle_powerup_ctrl

Overview:
- Frame-rate controller that sequences paddle-size power-ups. It turns brick-drop capture events into the PowOn / PaddleSizeUpPow / PaddleSizeDownPow controls consumed by the paddle block.
- Owns the power-up lifetime timer, same-type refresh, opposite-type switch-over through a normal-size gap, pause freeze and level-change clear.
- Sits between the brick/drop collision logic and the paddle; also feeds the HUD (warn/expiry, frames left).

Parameters:
- POW_FRAMES, 600, frames a power-up stays active (10 s at 60 Hz); legal 1..1023.
- GAP_FRAMES, 2, frames at normal size between an expiring type and a newly applied opposite type; legal 1..1023.
- WARN_FRAMES, 120, pow_warn asserted when the active timer is <= this value; legal 0..POW_FRAMES.

Ports:
- frame_clk  input  1  frame clock, one tick per video frame
- Reset  input  1  asynchronous, active-high reset
- levelChange  input  1  level transition; clears all power-up state
- noMore  input  1  game paused/over; freezes all timers
- capture_valid  input  1  one-frame pulse: paddle caught a power-up drop
- capture_type  input  2  01 = grow, 10 = shrink, 00/11 = ignored
- PowOn  output  1  power-up active (to paddle)
- PaddleSizeUpPow  output  1  active type is grow
- PaddleSizeDownPow  output  1  active type is shrink
- pow_warn  output  1  active and about to expire (HUD blink)
- pow_expired  output  1  one-frame pulse on natural expiry
- frames_left  output  10  remaining active frames; 0 when not ACTIVE

Behaviour:
- All outputs are registered. Decisions apply at the next frame_clk edge (1-frame latency).
- Reset: async, active-high. State IDLE, timer=0, gap=0, type=none, pending=none. All outputs 0.
- Priority each edge: Reset > levelChange > capture > timer advance. Pause (noMore) blocks only timer/gap decrement; captures are still accepted.
- Valid capture = capture_valid && capture_type in {01,10}. Any other capture is ignored with no state change.
- IDLE state:
  - Valid capture -> ACTIVE; type latched; timer=POW_FRAMES.
  - Outputs otherwise 0.
- ACTIVE state:
  - PowOn=1. PaddleSizeUpPow = (type==grow). PaddleSizeDownPow = (type==shrink). Never both 1.
  - Same-type capture: timer reloads to POW_FRAMES; this overrides expiry on the same edge.
  - Opposite-type capture -> SWITCH; pending=new type; gap=GAP_FRAMES.
  - No capture, noMore=0: if timer==1 -> IDLE, timer=0, pow_expired=1 for exactly that next frame; else timer decrements by 1.
  - noMore=1: timer holds.
  - PowOn stays high for exactly POW_FRAMES unpaused frames after the last load.
- SWITCH state:
  - PowOn=0 and both size flags 0, so the paddle returns to normal size for at least GAP_FRAMES frames.
  - Valid capture overwrites pending (last one wins); gap is not reloaded.
  - noMore=0: if gap==1 -> ACTIVE with type=pending, timer=POW_FRAMES, pending cleared; else gap decrements.
  - noMore=1: gap holds.
  - pow_expired is never asserted for a switch.
- levelChange: next state IDLE; timer, gap, type and pending cleared; all outputs 0. A capture on the same edge is discarded.
- frames_left = timer in ACTIVE, else 0.
- pow_warn = ACTIVE && timer <= WARN_FRAMES. With WARN_FRAMES=0 it is never asserted.
- Arithmetic: 10-bit unsigned counters. A decrement never occurs at 0 (guarded by the ==1 check), so there is no wrap.
- Reset mid-operation: immediate async clear to IDLE, regardless of state.

Test Plan:
- Reset, then grow capture at frame 10 -> frame 11: PowOn=1, PaddleSizeUpPow=1, frames_left=600. frames_left=120 at frame 491 with pow_warn=1. PowOn drops at frame 611, pow_expired=1 at frame 611 only.
- Grow active with frames_left=5, grow capture -> next frame frames_left=600, no pow_expired pulse.
- Grow active, shrink capture at frame N -> frames N+1..N+2: PowOn=0, flags 0. Frame N+3: PowOn=1, PaddleSizeDownPow=1, frames_left=600. A grow capture at N+1 instead -> grow applied at N+3.
- Active with frames_left=300, noMore held 50 frames -> frames_left stays 300, then resumes decrementing. Capture_type 11 or 00 pulses in any state -> no change.
- Shrink active or in SWITCH, levelChange together with capture_valid -> next frame all outputs 0, state IDLE. The capture is not applied afterwards.
- Assert Reset asynchronously mid-ACTIVE between clock edges -> outputs 0 immediately. After release, the first valid capture behaves as in the first scenario.
